// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M funct3 opcodes,
// FSM states and small opcode-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_mul_high(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_signed_a(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  assign dout = en ? (~din) + XLEN'(1) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shared accumulator/shift-register datapath,
// one bit per cycle, fixed XLEN-cycle latency for every operation.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CNT_W = ($clog2(XLEN + 1) > 5) ? $clog2(XLEN + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d, dz_q, dz_d;
  logic [XLEN-1:0]   acc_q, acc_d, sr_q, sr_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  op_e               op_in;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem, acc_nxt, sr_nxt;
  logic [2*XLEN-1:0] fix_in, fix_out;

  assign op_in = op_e'(op);
  assign sa    = op_signed_a(op_in) & a[XLEN-1];
  assign sb    = op_signed_b(op_in) & b[XLEN-1];

  muldiv_negate #(.XLEN(XLEN)) u_neg_a (.en(sa), .din(a), .dout(a_mag));
  muldiv_negate #(.XLEN(XLEN)) u_neg_b (.en(sb), .din(b), .dout(b_mag));

  // One iteration: multiply shifts {acc, sr} right after a conditional add;
  // divide shifts the dividend out of sr into acc and shifts quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, mcand_q} : '0);
    div_trial = {acc_q, sr_q[XLEN-1]};
    div_ok    = div_trial >= {1'b0, mcand_q};
    div_rem   = div_trial[XLEN-1:0] - mcand_q;
    if (op_is_div(op_q)) begin
      acc_nxt = div_ok ? div_rem : div_trial[XLEN-1:0];
      sr_nxt  = {sr_q[XLEN-2:0], div_ok};
    end else begin
      acc_nxt = mul_sum[XLEN:1];
      sr_nxt  = {mul_sum[0], sr_q[XLEN-1:1]};
    end
  end

  // Sign fix-up sees the values the final iteration is about to write.
  always_comb begin
    if (!op_is_div(op_q))     fix_in = {acc_nxt, sr_nxt};
    else if (op_is_rem(op_q)) fix_in = {{XLEN{1'b0}}, acc_nxt};
    else                      fix_in = {{XLEN{1'b0}}, sr_nxt};
  end

  muldiv_negate #(.XLEN(2*XLEN)) u_fix (.en(neg_q), .din(fix_in), .dout(fix_out));

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    mcand_d    = mcand_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      CALC: begin
        acc_d = acc_nxt;
        sr_d  = sr_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = FIN;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          result_d   = op_mul_high(op_q) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];
          div_zero_d = dz_q;
        end
      end
      default: begin
        if (start) begin
          state_d = CALC;
          busy_d  = 1'b1;
          op_d    = op_in;
          cnt_d   = '0;
          acc_d   = '0;
          sr_d    = a_mag;
          mcand_d = b_mag;
          dz_d    = op_is_div(op_in) && (b == '0);
          // A zero divisor keeps the all-ones quotient unsigned.
          if (!op_is_div(op_in))     neg_d = sa ^ sb;
          else if (op_is_rem(op_in)) neg_d = sa;
          else                       neg_d = (sa ^ sb) && (b != '0);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: datapath registers are reset along with control so a reset leaves no stale operand state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= '0;
      sr_q       <= '0;
      mcand_q    <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      mcand_q    <= mcand_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule
